// File: rtl/aes_mixcolumns_seq_if.sv
// Request/response bundle for the sequential MixColumns engine.
// The requester drives start/inv/state_in; the engine returns ready/state_out/valid_out.
interface aes_mixcolumns_seq_if #(
  parameter int NCOL = 4
);
  logic                 start;
  logic                 inv;
  logic [32*NCOL-1:0]   state_in;
  logic                 ready;
  logic [32*NCOL-1:0]   state_out;
  logic                 valid_out;

  modport master (
    output start, inv, state_in,
    input  ready, state_out, valid_out
  );

  modport slave (
    input  start, inv, state_in,
    output ready, state_out, valid_out
  );
endinterface

// File: rtl/aes_mixcolumns_seq.sv
// Sequential AES (Inv)MixColumns: processes CPC columns per clock over NCOL/CPC cycles.
// state | meaning
// IDLE  | ready=1, waiting for start; state_out holds the last result
// BUSY  | transforming one column group per edge; result published on the last group
module aes_mixcol_unit (
  input  logic        inv,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] b [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]  = col_in[31-8*i -: 8];
      x2[i] = xt(b[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
  end

  // 3a = 2a^a, 9a = 8a^a, 11a = 8a^2a^a, 13a = 8a^4a^a, 14a = 8a^4a^2a
  always_comb begin
    logic [7:0] f;
    logic [7:0] v;
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
      f = x2[i] ^ (x2[(i+1)%4] ^ b[(i+1)%4]) ^ b[(i+2)%4] ^ b[(i+3)%4];
      v = (x8[i] ^ x4[i] ^ x2[i])
        ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ b[(i+1)%4])
        ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ b[(i+2)%4])
        ^ (x8[(i+3)%4] ^ b[(i+3)%4]);
      col_out[31-8*i -: 8] = inv ? v : f;
    end
  end
endmodule

module aes_mixcolumns_seq #(
  parameter int NCOL = 4,
  parameter int CPC  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  aes_mixcolumns_seq_if.slave bus
);
  localparam int N  = NCOL / CPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = 32 * NCOL;

  generate
    if (NCOL < 1 || NCOL > 8 || CPC < 1 || (NCOL % CPC) != 0) begin : g_bad_param
      $error("aes_mixcolumns_seq: NCOL must be 1..8 and a multiple of CPC");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          mode;
  logic [W-1:0]  work, work_nxt;
  logic [W-1:0]  result;
  logic          valid_q;
  logic          load, step, last;
  logic [31:0]   col_in  [CPC];
  logic [31:0]   col_out [CPC];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CW'(N-1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // column c sits at bits [W-1-32c -: 32]; group k covers columns k*CPC .. k*CPC+CPC-1
  always_comb begin
    for (int j = 0; j < CPC; j++)
      col_in[j] = work[W-32-32*(int'(cnt)*CPC+j) +: 32];
  end

  generate
    for (genvar j = 0; j < CPC; j++) begin : g_unit
      aes_mixcol_unit u_col (
        .inv     (mode),
        .col_in  (col_in[j]),
        .col_out (col_out[j])
      );
    end
  endgenerate

  always_comb begin
    work_nxt = work;
    for (int j = 0; j < CPC; j++)
      work_nxt[W-32-32*(int'(cnt)*CPC+j) +: 32] = col_out[j];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work    <= '0;
      mode    <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        work <= bus.state_in;
        mode <= bus.inv;
        cnt  <= '0;
      end else if (step) begin
        work <= work_nxt;
        if (last) begin
          result  <= work_nxt;
          valid_q <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.state_out = result;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Bench for aes_mixcolumns_seq: three instances (CPC=1,2,4; NCOL=4) share one stimulus stream
// and are checked against a matrix-over-GF(2^8) reference model and fixed vectors.
module tb_aes_mixcolumns_seq;
  logic         clk;
  logic         reset_n;
  logic         start_v [3];
  logic         inv_s;
  logic [127:0] sin_s;
  logic         rdy  [3];
  logic         vld  [3];
  logic [127:0] sout [3];
  logic [127:0] prev [3];
  int           lat_n [3] = '{4, 2, 1};
  int           errors = 0;
  int           checks = 0;

  aes_mixcolumns_seq_if #(.NCOL(4)) ifc0 ();
  aes_mixcolumns_seq_if #(.NCOL(4)) ifc1 ();
  aes_mixcolumns_seq_if #(.NCOL(4)) ifc2 ();

  assign ifc0.start = start_v[0];  assign ifc0.inv = inv_s;  assign ifc0.state_in = sin_s;
  assign ifc1.start = start_v[1];  assign ifc1.inv = inv_s;  assign ifc1.state_in = sin_s;
  assign ifc2.start = start_v[2];  assign ifc2.inv = inv_s;  assign ifc2.state_in = sin_s;
  assign rdy[0] = ifc0.ready;  assign vld[0] = ifc0.valid_out;  assign sout[0] = ifc0.state_out;
  assign rdy[1] = ifc1.ready;  assign vld[1] = ifc1.valid_out;  assign sout[1] = ifc1.state_out;
  assign rdy[2] = ifc2.ready;  assign vld[2] = ifc2.valid_out;  assign sout[2] = ifc2.state_out;

  aes_mixcolumns_seq #(.NCOL(4), .CPC(1)) u_cpc1 (.clk(clk), .reset_n(reset_n), .bus(ifc0));
  aes_mixcolumns_seq #(.NCOL(4), .CPC(2)) u_cpc2 (.clk(clk), .reset_n(reset_n), .bus(ifc1));
  aes_mixcolumns_seq #(.NCOL(4), .CPC(4)) u_cpc4 (.clk(clk), .reset_n(reset_n), .bus(ifc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1);
  end

  // Reference: product of the circulant matrix with each column, generic GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [8:0] aa = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
    logic [7:0]   coef [4];
    logic [7:0]   byt  [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (iv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else    coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) byt[i] = s[127-32*c-8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], byt[k]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Issue one request to all three instances; entered and left just after a rising edge.
  task automatic do_op(input logic [127:0] in, input logic iv, input logic [127:0] exp,
                       input bit disturb);
    int nv [3] = '{0, 0, 0};
    for (int d = 0; d < 3; d++) start_v[d] = 1'b1;
    inv_s = iv;
    sin_s = in;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) start_v[d] = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
    if (disturb) begin inv_s = ~inv_s; sin_s = rnd128(); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (vld[d]) begin
          nv[d]++;
          if (nv[d] == 1) begin
            chk($sformatf("latency cpc_idx%0d", d), 128'(c), 128'(lat_n[d]));
            chk($sformatf("result cpc_idx%0d", d), sout[d], exp);
            prev[d] = sout[d];
          end
        end else begin
          chk($sformatf("hold cpc_idx%0d c%0d", d, c), sout[d], prev[d]);
        end
        chk($sformatf("ready cpc_idx%0d c%0d", d, c), 128'(rdy[d]), 128'(c >= lat_n[d]));
        start_v[d] = (disturb && c < lat_n[d]) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (disturb) begin inv_s = ~inv_s; sin_s = rnd128(); end
    end
    for (int d = 0; d < 3; d++) chk($sformatf("valid_count cpc_idx%0d", d), 128'(nv[d]), 128'd1);
  endtask

  typedef struct {
    logic [127:0] sin;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [127:0] hist_in  [40];
  logic         hist_inv [40];

  initial begin
    logic [127:0] r, m;
    logic         iv;
    bit           ev;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[2] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vecs[3] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[4] = '{128'h0, 1'b0, 128'h0};
    vecs[5] = '{128'h0, 1'b1, 128'h0};
    vecs[6] = '{128'h01010101_01010101_01010101_01010101, 1'b1, 128'h01010101_01010101_01010101_01010101};
    vecs[7] = '{128'h01000000_00010000_00000100_00000001, 1'b0, 128'h02010103_03020101_01030201_01010302};

    for (int d = 0; d < 3; d++) begin start_v[d] = 1'b0; prev[d] = '0; end
    inv_s   = 1'b0;
    sin_s   = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset ready cpc_idx%0d", d), 128'(rdy[d]), 128'd1);
      chk($sformatf("reset valid cpc_idx%0d", d), 128'(vld[d]), 128'd0);
      chk($sformatf("reset state_out cpc_idx%0d", d), sout[d], 128'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_op(vecs[i].sin, vecs[i].inv, vecs[i].exp, 1'b0);

    // Busy-time start pulses plus inv/state_in churn must not disturb the request in flight.
    do_op(vecs[2].sin, 1'b0, vecs[2].exp, 1'b1);
    do_op(vecs[1].sin, 1'b1, vecs[1].exp, 1'b1);

    // Reset in the middle of an operation.
    for (int d = 0; d < 3; d++) start_v[d] = 1'b1;
    inv_s = 1'b0;
    sin_s = vecs[0].sin;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midreset ready cpc_idx%0d", d), 128'(rdy[d]), 128'd1);
      chk($sformatf("midreset valid cpc_idx%0d", d), 128'(vld[d]), 128'd0);
      chk($sformatf("midreset state_out cpc_idx%0d", d), sout[d], 128'd0);
      prev[d] = '0;
    end
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("postreset valid cpc_idx%0d c%0d", d, c), 128'(vld[d]), 128'd0);
        chk($sformatf("postreset state_out cpc_idx%0d c%0d", d, c), sout[d], 128'd0);
      end
    end
    do_op(vecs[0].sin, 1'b0, vecs[0].exp, 1'b0);

    // Random round trips in both modes.
    for (int i = 0; i < 1000; i++) begin
      r  = rnd128();
      iv = 1'(i & 1);
      m  = model(r, iv);
      do_op(r, iv, m, 1'b0);
      do_op(m, ~iv, r, 1'b0);
    end

    // Back-to-back with start held high: acceptance every N+1 edges.
    for (int t = 0; t < 40; t++) begin
      for (int d = 0; d < 3; d++) start_v[d] = 1'b1;
      sin_s = rnd128();
      inv_s = 1'($urandom_range(0, 1));
      hist_in[t]  = sin_s;
      hist_inv[t] = inv_s;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        ev = ((t % (lat_n[d] + 1)) == lat_n[d]);
        chk($sformatf("b2b valid cpc_idx%0d t%0d", d, t), 128'(vld[d]), 128'(ev));
        if (ev)
          chk($sformatf("b2b result cpc_idx%0d t%0d", d, t), sout[d],
              model(hist_in[t-lat_n[d]], hist_inv[t-lat_n[d]]));
      end
    end
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    repeat (6) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
